// File: rtl/v188_mem_responder.sv
// V188 CPU memory bus target: byte RAM window with programmable wait states.
// Optional write protection is built when V188_MEMRESP_WP_EN is defined.
module v188_mem_responder #(
  parameter int          RAM_AW      = 14,
  parameter logic [19:0] BASE        = 20'h00000,
  parameter int          WAIT_STATES = 2
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic [19:0] iAddr,
  input  logic [7:0]  iMData,
  input  logic        iMRd,
  input  logic        iMWr,
`ifdef V188_MEMRESP_WP_EN
  input  logic        iWProt,
  output logic        oWpViol,
`endif
  output logic [7:0]  oMData,
  output logic        oReady,
  output logic        oHit
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam bit         NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t            state, stateNext;
  logic [3:0]        count;
  logic [RAM_AW-1:0] addrLatch;
  logic              isRead;
  logic [7:0]        dataReg;
  logic [7:0]        ram [0:(1 << RAM_AW) - 1];

  logic              hit, req, strobeHeld, enterDone, opRead, ramWe, wpBlock;
  logic [RAM_AW-1:0] ramAddr;

  assign hit        = (iAddr[19:RAM_AW] == BASE[19:RAM_AW]);
  assign req        = hit & (iMRd ^ iMWr);
  assign strobeHeld = isRead ? iMRd : iMWr;

  // With no wait states the access completes straight from IDLE, so the
  // live bus address and direction feed the RAM on that edge.
  assign opRead    = (state == IDLE) ? iMRd : isRead;
  assign ramAddr   = (state == IDLE) ? iAddr[RAM_AW-1:0] : addrLatch;
  assign enterDone = ((state == IDLE) & req & NO_WAIT)
                   | ((state == WAIT) & (count == 4'd0) & strobeHeld);

`ifdef V188_MEMRESP_WP_EN
  assign wpBlock = iWProt;
`else
  assign wpBlock = 1'b0;
`endif

  assign ramWe = enterDone & ~opRead & ~wpBlock & ~iReset;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge iClk) begin
    if (iReset) state <= IDLE;
    else        state <= stateNext;
  end

  // NOTE: each combinational output is given a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (req) stateNext = NO_WAIT ? DONE : WAIT;
      WAIT: begin
        if (!strobeHeld)          stateNext = IDLE;
        else if (count == 4'd0)   stateNext = DONE;
      end
      DONE: if (!strobeHeld) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    oReady = 1'b1;
    oHit   = 1'b0;
    oMData = 8'h00;
    unique case (state)
      IDLE: oReady = ~req;
      WAIT: begin
        oReady = 1'b0;
        oHit   = 1'b1;
      end
      DONE: begin
        oHit = 1'b1;
        if (isRead) oMData = dataReg;
      end
      default: oReady = 1'b1;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      count     <= 4'd0;
      addrLatch <= '0;
      isRead    <= 1'b0;
      dataReg   <= 8'h00;
`ifdef V188_MEMRESP_WP_EN
      oWpViol   <= 1'b0;
`endif
    end else begin
      if ((state == IDLE) && req) begin
        addrLatch <= iAddr[RAM_AW-1:0];
        isRead    <= iMRd;
        count     <= CNT_LOAD;
      end else if ((state == WAIT) && (count != 4'd0)) begin
        count <= count - 4'd1;
      end
      if (enterDone && opRead) dataReg <= ram[ramAddr];
`ifdef V188_MEMRESP_WP_EN
      oWpViol <= enterDone & ~opRead & iWProt;
`endif
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; only the
  // data register in front of it is cleared.
  always_ff @(posedge iClk) begin
    if (ramWe) ram[ramAddr] <= iMData;
  end

endmodule

// File: tb/tb_v188_mem_responder.sv
// Directed bench: two responders share one bus (2 wait states at 0x00000,
// 0 wait states at 0x80000); a scoreboard queue holds per-access expectations.
module tb_v188_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] addr = '0;
  logic [7:0]  mdata = '0;
  logic        mrd = 1'b0, mwr = 1'b0, wprot = 1'b0;
  logic [7:0]  dA, dB;
  logic        rA, rB, hA, hB, vA, vB;
  logic        busReady;
  logic [7:0]  busData;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    int         lat;
    logic [7:0] data;
    bit         hit;
    int         wpv;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [logic [19:0]];

  always #5 clk = ~clk;

  assign busReady = rA & rB;
  assign busData  = dA | dB;

  v188_mem_responder #(.RAM_AW(14), .BASE(20'h00000), .WAIT_STATES(2)) dutA (
    .iClk(clk), .iReset(reset), .iAddr(addr), .iMData(mdata), .iMRd(mrd), .iMWr(mwr),
`ifdef V188_MEMRESP_WP_EN
    .iWProt(wprot), .oWpViol(vA),
`endif
    .oMData(dA), .oReady(rA), .oHit(hA));

  v188_mem_responder #(.RAM_AW(14), .BASE(20'h80000), .WAIT_STATES(0)) dutB (
    .iClk(clk), .iReset(reset), .iAddr(addr), .iMData(mdata), .iMRd(mrd), .iMWr(mwr),
`ifdef V188_MEMRESP_WP_EN
    .iWProt(wprot), .oWpViol(vB),
`endif
    .oMData(dB), .oReady(rB), .oHit(hB));

`ifndef V188_MEMRESP_WP_EN
  assign vA = 1'b0;
  assign vB = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int expLat(input logic [19:0] a);
    if (a[19:14] == 6'h00) return 3;
    if (a[19:14] == 6'h20) return 1;
    return 0;
  endfunction

  // One complete access; expectations are pushed as it is driven and popped
  // once the bus reports completion.
  task automatic access(input string tag, input bit rd, input logic [19:0] a,
                        input logic [7:0] wd);
    exp_t e;
    int   low, wpc;
    logic [7:0] got;
    logic gotHit;
    e.tag  = tag;
    e.lat  = expLat(a);
    e.hit  = (e.lat > 0);
    e.data = (rd && e.hit) ? model[a] : 8'h00;
    e.wpv  = (!rd && e.hit && wprot) ? 1 : 0;
    sb.push_back(e);
    if (!rd && e.hit && !wprot) model[a] = wd;

    @(posedge clk); #1;
    addr = a; mdata = wd; mrd = rd; mwr = !rd;
    low = 0; wpc = 0;
    forever begin
      @(negedge clk);
      if (vA | vB) wpc++;
      if (busReady) break;
      low++;
      if (low > 40) break;
    end
    got    = busData;
    gotHit = hA | hB;
    @(posedge clk); #1;
    mrd = 1'b0; mwr = 1'b0;
    @(negedge clk);
    if (vA | vB) wpc++;
    @(posedge clk);

    e = sb.pop_front();
    chk({e.tag, ":latency"}, low, e.lat);
    chk({e.tag, ":data"}, {24'h0, got}, {24'h0, e.data});
    chk({e.tag, ":hit"}, {31'h0, gotHit}, {31'h0, e.hit});
`ifdef V188_MEMRESP_WP_EN
    chk({e.tag, ":wpviol"}, wpc, e.wpv);
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset:readyA", {31'h0, rA}, 32'h1);
    chk("reset:hitA",   {31'h0, hA}, 32'h0);
    chk("reset:dataA",  {24'h0, dA}, 32'h0);
    chk("reset:readyB", {31'h0, rB}, 32'h1);

    access("wrA5", 1'b0, 20'h00123, 8'hA5);
    access("rdA5", 1'b1, 20'h00123, 8'h00);
    access("wrTop", 1'b0, 20'h03FFF, 8'h77);
    access("wrBot", 1'b0, 20'h00000, 8'h11);
    access("rdTop", 1'b1, 20'h03FFF, 8'h00);
    access("rdBot", 1'b1, 20'h00000, 8'h00);
    access("rdOut", 1'b1, 20'h40000, 8'h00);
    access("rdEdge", 1'b1, 20'h04000, 8'h00);
    access("wrB", 1'b0, 20'h80010, 8'h3C);
    access("rdB", 1'b1, 20'h80010, 8'h00);

    // Write aborted during the first wait cycle must not reach the RAM.
    @(posedge clk); #1;
    addr = 20'h00123; mdata = 8'h5A; mwr = 1'b1;
    @(negedge clk);
    chk("abort:idleReady", {31'h0, rA}, 32'h0);
    @(posedge clk); #1 mwr = 1'b0;
    @(negedge clk);
    chk("abort:waitReady", {31'h0, rA}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("abort:ready", {31'h0, rA}, 32'h1);
    chk("abort:hit",   {31'h0, hA}, 32'h0);
    chk("abort:data",  {24'h0, dA}, 32'h0);
    access("rdAbort", 1'b1, 20'h00123, 8'h00);

    // Reset in the middle of a read.
    @(posedge clk); #1;
    addr = 20'h00123; mrd = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; mrd = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst:ready", {31'h0, rA}, 32'h1);
    chk("rst:hit",   {31'h0, hA}, 32'h0);
    chk("rst:data",  {24'h0, dA}, 32'h0);
    access("rdAfterRst", 1'b1, 20'h00123, 8'h00);

    // Both strobes together is illegal and must not start an access.
    @(posedge clk); #1;
    addr = 20'h00123; mdata = 8'hFF; mrd = 1'b1; mwr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("both:ready%0d", i), {31'h0, rA}, 32'h1);
      chk($sformatf("both:hit%0d", i),   {31'h0, hA}, 32'h0);
    end
    @(posedge clk); #1 mrd = 1'b0; mwr = 1'b0;
    access("rdAfterBoth", 1'b1, 20'h00123, 8'h00);

`ifdef V188_MEMRESP_WP_EN
    wprot = 1'b1;
    access("wrProt", 1'b0, 20'h00123, 8'hFF);
    wprot = 1'b0;
    access("rdProt", 1'b1, 20'h00123, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
